// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, X/Y counters, sync/blank decode, frame counter.
// Latency: counters and pixelTick move on the divider-wrap clk; hSync/vSync/blankN lag the counters by 1 clk.
// No backpressure: enable=0 freezes all state and forces the strobes low.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelTick,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN,
  output logic        startOfFrame,
  output logic [15:0] frameCount
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
  // A 1-bit divider is kept for CLK_DIV=1; it simply sits at 0 and wraps every clk.
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic             line_end;
  logic             frame_end;

  assign div_wrap  = (div == DIV_W'(CLK_DIV - 1));
  assign line_end  = (pixelX == 11'(H_TOTAL - 1));
  assign frame_end = (pixelY == 11'(V_TOTAL - 1));

  // Divider, raster counters, per-pixel strobe and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      pixelX       <= '0;
      pixelY       <= '0;
      pixelTick    <= 1'b0;
      startOfFrame <= 1'b0;
      frameCount   <= '0;
    end else if (enable) begin
      pixelTick    <= div_wrap;
      startOfFrame <= div_wrap && line_end && frame_end;
      if (div_wrap) begin
        div <= '0;
        if (line_end) begin
          pixelX <= '0;
          if (frame_end) begin
            pixelY     <= '0;
            frameCount <= frameCount + 16'd1;
          end else begin
            pixelY <= pixelY + 11'd1;
          end
        end else begin
          pixelX <= pixelX + 11'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end else begin
      pixelTick    <= 1'b0;
      startOfFrame <= 1'b0;
    end
  end

  // Sync and blank decoded from the current counters, so they land one clk after the counters move.
  always_ff @(posedge clk) begin
    if (reset) begin
      hSync  <= 1'b1;
      vSync  <= 1'b1;
      blankN <= 1'b0;
    end else if (enable) begin
      hSync  <= !((pixelX >= 11'(HS_START)) && (pixelX <= 11'(HS_END)));
      vSync  <= !((pixelY >= 11'(VS_START)) && (pixelY <= 11'(VS_END)));
      blankN <= (pixelX < 11'(H_ACTIVE)) && (pixelY < 11'(V_ACTIVE));
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunken rasters (CLK_DIV=2 and CLK_DIV=1) driven in lockstep.
// Expected outputs come from a count-based reference (enabled clks since reset) queued per clk.
// Covers reset, line/frame wrap, enable freeze at divider=1, mid-frame reset and random enable gaps.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 8
  localparam int FR = HT * VT;             // 120 ticks per frame

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        tick;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        sof;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic [10:0] x0, y0, x1, y1;
  logic        tk0, hs0, vs0, bl0, sf0, tk1, hs1, vs1, bl1, sf1;
  logic [15:0] fc0, fc1;

  int total = 0;
  int bad = 0;

  // Reference state per instance: enabled clks since reset and held sync values.
  int   n_m [2];
  int   div_m [2];
  logic hs_m [2];
  logic vs_m [2];
  logic bl_m [2];

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .pixelX(x0), .pixelY(y0), .pixelTick(tk0), .hSync(hs0), .vSync(vs0),
    .blankN(bl0), .startOfFrame(sf0), .frameCount(fc0));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .pixelX(x1), .pixelY(y1), .pixelTick(tk1), .hSync(hs1), .vSync(vs1),
    .blankN(bl1), .startOfFrame(sf1), .frameCount(fc1));

  // Advance the reference by one clk given the inputs seen at that edge.
  function automatic exp_t model(input int k, input logic rst, input logic en);
    exp_t e;
    int   d, tp, t, xp, yp;
    d = div_m[k];
    if (rst) begin
      n_m[k]  = 0;
      hs_m[k] = 1'b1;
      vs_m[k] = 1'b1;
      bl_m[k] = 1'b0;
      e = '{x: 11'd0, y: 11'd0, tick: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0, sof: 1'b0, fc: 16'd0};
      return e;
    end
    e.tick = 1'b0;
    e.sof  = 1'b0;
    if (en) begin
      tp = n_m[k] / d;
      xp = tp % HT;
      yp = (tp / HT) % VT;
      hs_m[k] = !(xp >= HA + HF && xp < HA + HF + HS);
      vs_m[k] = !(yp >= VA + VF && yp < VA + VF + VS);
      bl_m[k] = (xp < HA) && (yp < VA);
      n_m[k]  = n_m[k] + 1;
      e.tick  = (n_m[k] % d) == 0;
      e.sof   = e.tick && ((n_m[k] / d) % FR == 0);
    end
    t    = n_m[k] / d;
    e.x  = 11'(t % HT);
    e.y  = 11'((t / HT) % VT);
    e.fc = 16'((t / FR) % 65536);
    e.hs = hs_m[k];
    e.vs = vs_m[k];
    e.bl = bl_m[k];
    return e;
  endfunction

  task automatic check(input string who, input exp_t e,
                       input logic [10:0] x, input logic [10:0] y, input logic tk,
                       input logic h, input logic v, input logic b, input logic s,
                       input logic [15:0] f);
    total++;
    assert (x === e.x) else begin bad++; $error("FAIL %s pixelX got=%0d exp=%0d", who, x, e.x); end
    total++;
    assert (y === e.y) else begin bad++; $error("FAIL %s pixelY got=%0d exp=%0d", who, y, e.y); end
    total++;
    assert (tk === e.tick) else begin bad++; $error("FAIL %s pixelTick got=%b exp=%b", who, tk, e.tick); end
    total++;
    assert (h === e.hs) else begin bad++; $error("FAIL %s hSync got=%b exp=%b", who, h, e.hs); end
    total++;
    assert (v === e.vs) else begin bad++; $error("FAIL %s vSync got=%b exp=%b", who, v, e.vs); end
    total++;
    assert (b === e.bl) else begin bad++; $error("FAIL %s blankN got=%b exp=%b", who, b, e.bl); end
    total++;
    assert (s === e.sof) else begin bad++; $error("FAIL %s startOfFrame got=%b exp=%b", who, s, e.sof); end
    total++;
    assert (f === e.fc) else begin bad++; $error("FAIL %s frameCount got=%0d exp=%0d", who, f, e.fc); end
  endtask

  // One clk: drive inputs mid-cycle, queue the expectation, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic en);
    exp_t e0, e1;
    @(negedge clk);
    reset  = rst;
    enable = en;
    q0.push_back(model(0, rst, en));
    q1.push_back(model(1, rst, en));
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("div2", e0, x0, y0, tk0, hs0, vs0, bl0, sf0, fc0);
    check("div1", e1, x1, y1, tk1, hs1, vs1, bl1, sf1, fc1);
  endtask

  initial begin
    div_m[0] = 2;
    div_m[1] = 1;
    n_m[0] = 0;
    n_m[1] = 0;
    hs_m[0] = 1'b1; hs_m[1] = 1'b1;
    vs_m[0] = 1'b1; vs_m[1] = 1'b1;
    bl_m[0] = 1'b0; bl_m[1] = 1'b0;

    // Reset with enable low, then reset with enable high: reset must win.
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Two full frames plus a line for the divided raster (four frames for CLK_DIV=1).
    repeat (2 * FR * 2 + 2 * HT) step(1'b0, 1'b1);

    // Freeze for 7 clks while the divider sits at 1, then resume.
    while ((n_m[0] % 2) != 1) step(1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);

    // Freeze while the divider sits at 0.
    while ((n_m[0] % 2) != 0) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    // Random enable gaps across a frame boundary.
    repeat (400) step(1'b0, 1'($urandom_range(0, 3) != 0));

    // Mid-frame single-clk reset, then run two more frames.
    while (((n_m[0] / 2) % FR) != 3 * HT + 6) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2 * FR * 2 + 5) step(1'b0, 1'b1);

    // Reset while disabled, then hold disabled: blankN stays 0, nothing moves.
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
